// File: rtl/timer_irq_source.sv
// Memory-mapped countdown timer driving one hwInt bit; CTRL/PRESET/COUNT on a
// word-addressed bridge port, acknowledged by rewriting CTRL.
module timer_irq_source #(
   parameter logic [31:0] PRESET_INIT = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   state_t      r_state;
   logic [3:0]  r_ctrl;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic        r_irq_pend;

   logic        w_en;
   logic [1:0]  w_mode;
   logic        w_im;
   logic        w_ctrl_wr;
   logic        w_preset_wr;

   assign w_en        = r_ctrl[0];
   assign w_mode      = r_ctrl[2:1];
   assign w_im        = r_ctrl[3];
   assign w_ctrl_wr   = we && (addr == 2'd0);
   assign w_preset_wr = we && (addr == 2'd1);

   assign irq = r_irq_pend & w_im;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ctrl     <= '0;
         r_preset   <= PRESET_INIT;
         r_count    <= '0;
         r_irq_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_en) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_count <= r_preset;
               r_state <= S_CNT;
            end
            S_CNT: begin
               if (!w_en) begin
                  r_state <= S_IDLE;
               end else if (r_count > 32'd1) begin
                  r_count <= r_count - 32'd1;
               end else begin
                  r_count    <= '0;
                  r_irq_pend <= 1'b1;
                  r_state    <= S_INT;
               end
            end
            S_INT: begin
               if (w_mode == 2'd1) begin
                  r_irq_pend <= 1'b0;
                  r_state    <= S_LOAD;
               end else begin
                  r_ctrl[0] <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         // Bus writes come last so they override the FSM's EN clear and pend set.
         if (w_ctrl_wr) begin
            r_ctrl     <= din[3:0];
            r_irq_pend <= 1'b0;
         end
         if (w_preset_wr) r_preset <= din;
      end
   end

   always_comb begin
      dout = '0;
      case (addr)
         2'd0:    dout = {28'd0, r_ctrl};
         2'd1:    dout = r_preset;
         2'd2:    dout = r_count;
         default: dout = '0;
      endcase
   end

endmodule

// File: tb/tb_timer_irq_source.sv
// Self-checking bench for timer_irq_source: directed test-plan steps plus
// random bus traffic against a schedule-based reference model.
module tb_timer_irq_source;

   localparam logic [31:0] PI = 32'd7;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   timer_irq_source #(.PRESET_INIT(PI)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Reference model: a run is timed by its age in edges since EN was seen idle.
   // Age 2 loads PRESET; the count window ends at age L+2 (L = max(PRESET,1))
   // where the interrupt fires; age L+3 services it.
   logic        m_en, m_im, m_pend;
   logic [1:0]  m_mode;
   logic [31:0] m_preset, m_count;
   bit          m_run;
   longint      m_age, m_len;

   task automatic model_reset();
      m_en = 1'b0; m_im = 1'b0; m_mode = 2'd0; m_pend = 1'b0;
      m_preset = PI; m_count = '0; m_run = 1'b0; m_age = 0; m_len = 1;
   endtask

   task automatic model_step(input logic [1:0] a, input logic w, input logic [31:0] d);
      if (!m_run) begin
         if (m_en) begin m_run = 1'b1; m_age = 1; end
      end else begin
         m_age = m_age + 1;
         if (m_age == 2) begin
            m_count = m_preset;
            m_len   = (m_preset == 0) ? 1 : longint'(m_preset);
         end else if (m_age <= m_len + 2) begin
            if (!m_en) m_run = 1'b0;
            else if (m_age <= m_len + 1) m_count = m_count - 32'd1;
            else begin m_count = '0; m_pend = 1'b1; end
         end else begin
            if (m_mode == 2'd1) begin m_pend = 1'b0; m_age = 1; end
            else begin m_en = 1'b0; m_run = 1'b0; end
         end
      end
      if (w && a == 2'd0) begin
         m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_pend = 1'b0;
      end
      if (w && a == 2'd1) m_preset = d;
   endtask

   function automatic logic [31:0] mread(input int a);
      case (a)
         0:       return {28'd0, m_im, m_mode, m_en};
         1:       return m_preset;
         2:       return m_count;
         default: return 32'd0;
      endcase
   endfunction

   function automatic string rname(input int a);
      case (a)
         0:       return "dout_ctrl";
         1:       return "dout_preset";
         2:       return "dout_count";
         default: return "dout_rsvd";
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = dout;
   endtask

   task automatic cycle(input logic [1:0] a, input logic w, input logic [31:0] d);
      addr = a; we = w; din = d;
      @(posedge clk);
      model_step(a, w, d);
      #1;
      we = 1'b0; din = '0;
      chk("irq", {31'd0, irq}, {31'd0, m_pend & m_im});
      for (int i = 0; i < 4; i++) begin
         addr = i[1:0];
         #1;
         chk(rname(i), dout, mread(i));
      end
   endtask

   task automatic idle();
      cycle(2'd0, 1'b0, 32'd0);
   endtask

   task automatic reset_checks();
      logic [31:0] v;
      chk("rst_irq", {31'd0, irq}, 32'd0);
      rd(2'd0, v); chk("rst_ctrl", v, 32'd0);
      rd(2'd1, v); chk("rst_preset", v, PI);
      rd(2'd2, v); chk("rst_count", v, 32'd0);
      rd(2'd3, v); chk("rst_rsvd", v, 32'd0);
   endtask

   task automatic do_reset();
      #1 reset = 1'b1;
      #1;
      reset_checks();
      model_reset();
      @(posedge clk);
      #3 reset = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      int unsigned r;
      reset = 1'b1; addr = '0; we = 1'b0; din = '0;
      model_reset();
      #1;
      reset_checks();
      @(posedge clk);
      #3 reset = 1'b0;

      // MODE0 one-shot, PRESET=3
      cycle(2'd1, 1'b1, 32'd3);
      cycle(2'd0, 1'b1, 32'h9);
      idle();
      idle(); rd(2'd2, v); chk("A_e2_count", v, 32'd3);
      idle(); rd(2'd2, v); chk("A_e3_count", v, 32'd2);
      idle(); rd(2'd2, v); chk("A_e4_count", v, 32'd1);
      chk("A_e4_irq", {31'd0, irq}, 32'd0);
      idle(); chk("A_e5_irq", {31'd0, irq}, 32'd1);
      idle(); rd(2'd0, v); chk("A_e6_ctrl", v, 32'h8);
      repeat (3) idle();
      chk("A_irq_held", {31'd0, irq}, 32'd1);
      cycle(2'd0, 1'b1, 32'h0);
      chk("A_ack_irq", {31'd0, irq}, 32'd0);

      // MODE1 auto-reload, PRESET=2
      cycle(2'd1, 1'b1, 32'd2);
      cycle(2'd0, 1'b1, 32'hB);
      for (int k = 1; k <= 12; k++) begin
         idle();
         chk("B_pulse", {31'd0, irq}, (k % 4 == 0) ? 32'd1 : 32'd0);
      end
      cycle(2'd0, 1'b1, 32'h0);
      repeat (3) idle();
      cycle(2'd0, 1'b1, 32'h3);
      for (int k = 1; k <= 8; k++) begin
         idle();
         chk("B_masked_irq", {31'd0, irq}, 32'd0);
         if (k == 4) begin rd(2'd2, v); chk("B_masked_cnt0", v, 32'd0); end
         if (k == 6) begin rd(2'd2, v); chk("B_masked_reload", v, 32'd2); end
      end
      cycle(2'd0, 1'b1, 32'h0);
      repeat (3) idle();

      // PRESET 0 and 1 both fire at E3
      for (int p = 0; p < 2; p++) begin
         cycle(2'd1, 1'b1, p);
         cycle(2'd0, 1'b1, 32'h9);
         idle();
         idle(); chk("C_e2_irq", {31'd0, irq}, 32'd0);
         idle(); chk("C_e3_irq", {31'd0, irq}, 32'd1);
         cycle(2'd0, 1'b1, 32'h0);
         repeat (3) idle();
      end

      // disable mid-count, then re-enable
      cycle(2'd1, 1'b1, 32'd10);
      cycle(2'd0, 1'b1, 32'h9);
      repeat (6) idle();
      rd(2'd2, v); chk("D_count6", v, 32'd6);
      cycle(2'd0, 1'b1, 32'h8);
      repeat (4) idle();
      rd(2'd2, v); chk("D_frozen", v, 32'd5);
      chk("D_no_irq", {31'd0, irq}, 32'd0);
      cycle(2'd0, 1'b1, 32'h9);
      idle();
      idle(); rd(2'd2, v); chk("D_reload", v, 32'd10);
      cycle(2'd0, 1'b1, 32'h0);
      repeat (3) idle();

      // CTRL write collisions on INT edge and on fire edge
      cycle(2'd1, 1'b1, 32'd1);
      cycle(2'd0, 1'b1, 32'h9);
      repeat (3) idle();
      chk("E_fire_irq", {31'd0, irq}, 32'd1);
      cycle(2'd0, 1'b1, 32'h9);
      chk("E_int_wr_irq", {31'd0, irq}, 32'd0);
      rd(2'd0, v); chk("E_int_wr_ctrl", v, 32'h9);
      idle();
      idle();
      cycle(2'd0, 1'b1, 32'h9);
      chk("E_fire_wr_irq", {31'd0, irq}, 32'd0);
      idle();
      rd(2'd0, v); chk("E_en_cleared", v, 32'h8);
      cycle(2'd2, 1'b1, 32'hDEAD_BEEF);
      rd(2'd2, v); chk("E_count_ro", v, 32'd0);
      cycle(2'd3, 1'b1, 32'hFFFF_FFFF);
      rd(2'd3, v); chk("E_rsvd", v, 32'd0);
      cycle(2'd0, 1'b1, 32'h0);

      // random bus traffic
      repeat (600) begin
         r = $urandom_range(0, 11);
         if (r == 0)      cycle(2'd0, 1'b1, $urandom);
         else if (r == 1) cycle(2'd1, 1'b1, $urandom_range(0, 5));
         else if (r == 2) cycle(2'($urandom_range(2, 3)), 1'b1, $urandom);
         else             cycle(2'($urandom_range(0, 3)), 1'b0, $urandom);
      end

      // async reset mid-count and with irq high
      cycle(2'd0, 1'b1, 32'h0);
      repeat (3) idle();
      cycle(2'd1, 1'b1, 32'd8);
      cycle(2'd0, 1'b1, 32'h9);
      repeat (5) idle();
      rd(2'd2, v); chk("R_count5", v, 32'd5);
      do_reset();
      cycle(2'd1, 1'b1, 32'd1);
      cycle(2'd0, 1'b1, 32'h9);
      repeat (4) idle();
      chk("R_irq_high", {31'd0, irq}, 32'd1);
      do_reset();
      idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
